// File: rtl/rv_divide.sv
// Iterative radix-2 restoring divider for the RV32M divide group
// (DIV, DIVU, REM, REMU). One operation is accepted in IDLE. The divider
// then iterates 32 steps while holding the pipeline busy, corrects signs,
// and presents the result in DONE until the first unstalled edge.
// Divide-by-zero and signed overflow return the architectural values and
// never trap.
//
// Ports:
//   clk_i      clock
//   rst_i      asynchronous, active-high reset
//   x_stall_i  pipeline stall; freezes all divider state
//   x_kill_i   flush; aborts any operation (beats stall and start)
//   d_start_i  request a new operation (sampled in IDLE only)
//   d_rs1_i    dividend
//   d_rs2_i    divisor
//   d_fun_i    funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU, others DIVU
//   x_busy_o   high in CALC and FIX
//   w_valid_o  high in DONE
//   w_rd_o     quotient or remainder
module rv_divide #(
    parameter bit g_early_exit = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        d_start_i,
    input  logic [31:0] d_rs1_i,
    input  logic [31:0] d_rs2_i,
    input  logic [2:0]  d_fun_i,
    output logic        x_busy_o,
    output logic        w_valid_o,
    output logic [31:0] w_rd_o
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [2:0]      fun_q, fun_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [W-1:0]    rd_q, rd_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;

    // Operand decode at acceptance
    logic            in_signed_c, in_rem_c, in_zero_c, in_ovf_c;
    logic [W-1:0]    abs1_c, abs2_c;

    always_comb begin
        in_signed_c = d_fun_i[2] & ~d_fun_i[0];
        in_rem_c    = d_fun_i[2] & d_fun_i[1];
        in_zero_c   = (d_rs2_i == '0);
        in_ovf_c    = in_signed_c && (d_rs1_i == 32'h8000_0000)
                                  && (d_rs2_i == 32'hFFFF_FFFF);
        abs1_c      = (in_signed_c && d_rs1_i[W-1]) ? W'(-d_rs1_i) : d_rs1_i;
        abs2_c      = (in_signed_c && d_rs2_i[W-1]) ? W'(-d_rs2_i) : d_rs2_i;
    end

    // One restoring step on the held operands
    logic [W:0]      rem_sh_c;
    logic [W+1:0]    trial_c;

    always_comb begin
        rem_sh_c = {rem_q, quo_q[W-1]};
        trial_c  = {1'b0, rem_sh_c} - {2'b00, dvs_q};
    end

    // Sign correction and result selection for FIX
    logic            q_signed_c, q_rem_c;
    logic [W-1:0]    q_fin_c, r_fin_c;

    always_comb begin
        q_signed_c = fun_q[2] & ~fun_q[0];
        q_rem_c    = fun_q[2] & fun_q[1];
        q_fin_c    = (q_signed_c && negq_q) ? W'(-quo_q) : quo_q;
        r_fin_c    = (q_signed_c && negr_q) ? W'(-rem_q) : rem_q;
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        fun_d   = fun_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        rd_d    = rd_q;

        if (x_kill_i) begin
            state_d = S_IDLE;
            count_d = '0;
        end else if (!x_stall_i) begin
            case (state_q)
                S_IDLE: begin
                    if (d_start_i) begin
                        fun_d   = d_fun_i;
                        // A zero divisor leaves the all-ones quotient unsigned
                        negq_d  = in_signed_c & (d_rs1_i[W-1] ^ d_rs2_i[W-1])
                                  & ~in_zero_c;
                        negr_d  = in_signed_c & d_rs1_i[W-1];
                        count_d = '0;
                        rem_d   = '0;
                        quo_d   = abs1_c;
                        dvs_d   = abs2_c;
                        if (g_early_exit && in_zero_c) begin
                            rd_d    = in_rem_c ? d_rs1_i : 32'hFFFF_FFFF;
                            state_d = S_DONE;
                        end else if (g_early_exit && in_ovf_c) begin
                            rd_d    = in_rem_c ? 32'h0000_0000 : 32'h8000_0000;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (!trial_c[W+1]) begin
                        rem_d = trial_c[W-1:0];
                        quo_d = {quo_q[W-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh_c[W-1:0];
                        quo_d = {quo_q[W-2:0], 1'b0};
                    end
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(W - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    rd_d    = q_rem_c ? r_fin_c : q_fin_c;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d  = (state_d == S_CALC) || (state_d == S_FIX);
        valid_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            fun_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            fun_q   <= fun_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign x_busy_o  = busy_q;
    assign w_valid_o = valid_q;
    assign w_rd_o    = rd_q;

endmodule

// File: tb/tb_rv_divide.sv
// Directed bench for rv_divide. Two instances share all inputs: u_dut has
// early exit enabled, u_dut_ne iterates every case. Latency is counted in
// edges after the accepting edge E0.
module tb_rv_divide;

    logic        clk;
    logic        rst;
    logic        x_stall;
    logic        x_kill;
    logic        d_start;
    logic [31:0] d_rs1;
    logic [31:0] d_rs2;
    logic [2:0]  d_fun;
    logic        busy_m, valid_m, busy_n, valid_n;
    logic [31:0] rd_m, rd_n;

    int          n_vec;
    int          n_err;
    int          edges;
    int          v_main, v_ne;
    int          busy_cnt, valid_cnt;
    logic [31:0] rd_main, rd_ne;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    rv_divide #(.g_early_exit(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
        .d_start_i(d_start), .d_rs1_i(d_rs1), .d_rs2_i(d_rs2), .d_fun_i(d_fun),
        .x_busy_o(busy_m), .w_valid_o(valid_m), .w_rd_o(rd_m)
    );

    rv_divide #(.g_early_exit(1'b0)) u_dut_ne (
        .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
        .d_start_i(d_start), .d_rs1_i(d_rs1), .d_rs2_i(d_rs2), .d_fun_i(d_fun),
        .x_busy_o(busy_n), .w_valid_o(valid_n), .w_rd_o(rd_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Observe both instances just after an edge
    task automatic sample();
        if (busy_m) busy_cnt++;
        if (valid_m || valid_n) valid_cnt++;
        if (valid_m && v_main < 0) begin
            v_main  = edges;
            rd_main = rd_m;
        end
        if (valid_n && v_ne < 0) begin
            v_ne  = edges;
            rd_ne = rd_n;
        end
    endtask

    task automatic tick(input logic st, input logic kl);
        @(negedge clk);
        x_stall = st;
        x_kill  = kl;
        @(posedge clk);
        #1;
        edges++;
        sample();
    endtask

    // One settling edge, then present the request for exactly one edge (E0)
    task automatic start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        tick(1'b0, 1'b0);
        @(negedge clk);
        d_start = 1'b1;
        d_fun   = f;
        d_rs1   = a;
        d_rs2   = b;
        x_stall = 1'b0;
        x_kill  = 1'b0;
        @(posedge clk);
        #1;
        d_start   = 1'b0;
        edges     = 0;
        v_main    = -1;
        v_ne      = -1;
        busy_cnt  = 0;
        valid_cnt = 0;
        sample();
    endtask

    task automatic wait_valid();
        while ((v_main < 0 || v_ne < 0) && edges < 80) begin
            tick(1'b0, 1'b0);
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit early);
        start(f, a, b);
        wait_valid();
        chk({tag, " rd"},      rd_main,        exp);
        chk({tag, " lat"},     32'(v_main),    early ? 32'd0 : 32'd33);
        chk({tag, " busy"},    32'(busy_cnt),  early ? 32'd0 : 32'd33);
        chk({tag, " rd_ne"},   rd_ne,          exp);
        chk({tag, " lat_ne"},  32'(v_ne),      32'd33);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        edges   = 0;
        rst     = 1'b1;
        x_stall = 1'b0;
        x_kill  = 1'b0;
        d_start = 1'b0;
        d_rs1   = '0;
        d_rs2   = '0;
        d_fun   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy",  {31'b0, busy_m},  32'd0);
        chk("reset valid", {31'b0, valid_m}, 32'd0);
        chk("reset rd",    rd_m,             32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Main function and sign handling
        do_op("div 100/7",     F_DIV,  32'd100,       32'd7,          32'd14,        1'b0);
        do_op("rem 100/7",     F_REM,  32'd100,       32'd7,          32'd2,         1'b0);
        do_op("rem -7/2",      F_REM,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0);
        do_op("div -7/2",      F_DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0);
        do_op("divu max/1",    F_DIVU, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 1'b0);
        do_op("remu max/16",   F_REMU, 32'hFFFF_FFFF, 32'h10,         32'hF,         1'b0);
        do_op("fun000 as divu", 3'b000, 32'hFFFF_FFF9, 32'd7,         32'h2492_4923, 1'b0);

        // Divide by zero and signed overflow
        do_op("div 5/0",       F_DIV,  32'd5,         32'd0,          32'hFFFF_FFFF, 1'b1);
        do_op("remu 5/0",      F_REMU, 32'd5,         32'd0,          32'd5,         1'b1);
        do_op("div -5/0",      F_DIV,  32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF, 1'b1);
        do_op("rem -5/0",      F_REM,  32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 1'b1);
        do_op("div ovf",       F_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1'b1);
        do_op("rem ovf",       F_REM,  32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         1'b1);

        // Stall for 5 edges once count reaches 10, then hold DONE under stall
        start(F_DIVU, 32'd1000, 32'd3);
        repeat (10) tick(1'b0, 1'b0);
        repeat (5)  tick(1'b1, 1'b0);
        wait_valid();
        chk("stall rd",     rd_main,     32'd333);
        chk("stall lat",    32'(v_main), 32'd38);
        chk("stall lat_ne", 32'(v_ne),   32'd38);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            chk("done hold valid", {31'b0, valid_m}, 32'd1);
            chk("done hold rd",    rd_m,             32'd333);
        end
        tick(1'b0, 1'b0);
        chk("done release", {31'b0, valid_m}, 32'd0);

        // Kill at count=20
        start(F_DIVU, 32'd1000, 32'd3);
        repeat (20) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("kill busy",  {31'b0, busy_m},  32'd0);
        chk("kill valid", {31'b0, valid_m}, 32'd0);
        valid_cnt = 0;
        repeat (40) tick(1'b0, 1'b0);
        chk("kill no result", 32'(valid_cnt), 32'd0);

        // Start together with kill is refused
        @(negedge clk);
        d_start = 1'b1;
        d_fun   = F_DIV;
        d_rs1   = 32'd100;
        d_rs2   = 32'd7;
        x_kill  = 1'b1;
        @(posedge clk);
        #1;
        d_start = 1'b0;
        x_kill  = 1'b0;
        chk("start+kill busy",    {31'b0, busy_m}, 32'd0);
        chk("start+kill busy_ne", {31'b0, busy_n}, 32'd0);

        // Reset mid-CALC clears outputs immediately
        start(F_DIV, 32'd100, 32'd7);
        repeat (5) tick(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst busy",  {31'b0, busy_m},  32'd0);
        chk("rst valid", {31'b0, valid_m}, 32'd0);
        chk("rst rd",    rd_m,             32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("div 9/3 after rst", F_DIV, 32'd9, 32'd3, 32'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
